// File: rtl/datapath_unit.sv
// Execution datapath: 4x8 register file, 8-bit ALU with registered NZCV flags,
// 16x8 data RAM with a host preload port. One instruction completes per clock.
module datapath_unit #(
  parameter int DW     = 8,
  parameter int MDEPTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      WE,
  input  logic                      ALUorM,
  input  logic [2:0]                ALUCntr,
  input  logic                      ALUSrc2,
  input  logic [1:0]                RDst3,
  input  logic [1:0]                RSrc1,
  input  logic [DW-1:0]             Src2,
  output logic [3:0]                ALUFlags,
  output logic [DW-1:0]             result,
  input  logic                      ld_en,
  input  logic [$clog2(MDEPTH)-1:0] ld_addr,
  input  logic [DW-1:0]             ld_data,
  input  logic [1:0]                dbg_sel,
  output logic [DW-1:0]             dbg_reg
);

  localparam int AW = $clog2(MDEPTH);

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_SHL  = 3'b101,
    OP_SHR  = 3'b110,
    OP_PASS = 3'b111
  } alu_op_e;

  logic [DW-1:0] regs_q  [4];
  logic [DW-1:0] regs_d  [4];
  logic [DW-1:0] mem_q   [MDEPTH];
  logic [DW-1:0] mem_d   [MDEPTH];
  logic [3:0]    flags_q;
  logic [3:0]    flags_d;

  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic [DW-1:0] alu_res;
  logic [DW:0]   alu_ext;
  logic          alu_c;
  logic          alu_v;
  logic [DW-1:0] ram_rdata;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    op_a    = regs_q[RSrc1];
    op_b    = ALUSrc2 ? Src2 : regs_q[Src2[1:0]];
    alu_ext = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    unique case (alu_op_e'(ALUCntr))
      OP_ADD: begin
        alu_ext = {1'b0, op_a} + {1'b0, op_b};
        alu_res = alu_ext[DW-1:0];
        alu_c   = alu_ext[DW];
        alu_v   = (op_a[DW-1] == op_b[DW-1]) && (alu_res[DW-1] != op_a[DW-1]);
      end
      OP_SUB: begin
        // Carry is the inverted borrow, so C=1 means A >= B unsigned.
        alu_ext = {1'b0, op_a} - {1'b0, op_b};
        alu_res = alu_ext[DW-1:0];
        alu_c   = ~alu_ext[DW];
        alu_v   = (op_a[DW-1] != op_b[DW-1]) && (alu_res[DW-1] != op_a[DW-1]);
      end
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_SHL: begin
        alu_res = {op_a[DW-2:0], 1'b0};
        alu_c   = op_a[DW-1];
      end
      OP_SHR: begin
        alu_res = {1'b0, op_a[DW-1:1]};
        alu_c   = op_a[0];
      end
      OP_PASS: alu_res = op_b;
      default: alu_res = '0;
    endcase

    flags_d   = {alu_res[DW-1], alu_res == '0, alu_c, alu_v};
    // Reads come from the registered array, so same-cycle host writes return old data.
    ram_rdata = mem_q[alu_res[AW-1:0]];
    result    = ALUorM ? ram_rdata : alu_res;

    regs_d = regs_q;
    if (WE) regs_d[RDst3] = result;
    mem_d = mem_q;
    if (ld_en) mem_d[ld_addr] = ld_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the RAM is cleared on reset like the registers, so it maps to flops, not a RAM macro.
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
      for (int i = 0; i < MDEPTH; i++) mem_q[i] <= '0;
      flags_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      regs_q  <= regs_d;
      mem_q   <= mem_d;
      flags_q <= flags_d;
    end
  end

  assign ALUFlags = flags_q;
  assign dbg_reg  = regs_q[dbg_sel];

endmodule
